// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM port between buffered download writes and VFD pixel reads
module sdram_port_arbiter #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 8,
  parameter int TMO    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_data,
  output logic              dl_wait,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_din,
  output logic              sd_we,
  output logic              sd_rd,
  input  logic [DATA_W-1:0] sd_dout,
  input  logic              sd_ack,
  output logic              tmo_err
);
  typedef enum logic [2:0] {IDLE, ISSUE_W, ISSUE_R, WAIT_W, WAIT_R} state_t;
  state_t state;
  logic full, last_w;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic [7:0] cnt;
  logic w_pend, r_pend, grant_w, waiting, tmo, done, free;
  // a read whose rd_valid is showing this cycle is finished, not pending again
  always_comb begin
    w_pend  = full | dl_wr;
    r_pend  = rd_req & ~rd_valid;
    grant_w = w_pend & (~r_pend | ~last_w);
    waiting = (state == WAIT_W) | (state == WAIT_R);
    tmo     = waiting & ~sd_ack & (cnt == 8'(TMO - 1));
    done    = waiting & (sd_ack | tmo);
    free    = done & (state == WAIT_W);
  end
  assign dl_wait = full;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      full     <= 1'b0;
      last_w   <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      cnt      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      sd_addr  <= '0;
      sd_din   <= '0;
      sd_we    <= 1'b0;
      sd_rd    <= 1'b0;
      tmo_err  <= 1'b0;
    end else begin
      sd_we    <= 1'b0;
      sd_rd    <= 1'b0;
      rd_valid <= 1'b0;
      if (dl_wr && (!full || free)) begin
        buf_addr <= dl_addr;
        buf_data <= dl_data;
        full     <= 1'b1;
      end else if (free) begin
        full <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (grant_w) begin
            state  <= ISSUE_W;
            last_w <= 1'b1;
          end else if (r_pend) begin
            state  <= ISSUE_R;
            last_w <= 1'b0;
          end
        end
        ISSUE_W: begin
          state   <= WAIT_W;
          sd_we   <= 1'b1;
          sd_addr <= buf_addr;
          sd_din  <= buf_data;
          cnt     <= '0;
        end
        ISSUE_R: begin
          state   <= WAIT_R;
          sd_rd   <= 1'b1;
          sd_addr <= rd_addr;
          cnt     <= '0;
        end
        WAIT_W, WAIT_R: begin
          if (done) begin
            state <= IDLE;
            if (state == WAIT_R) begin
              rd_data  <= sd_ack ? sd_dout : '0;
              rd_valid <= 1'b1;
            end
            if (tmo) tmo_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: randomized bench with download/reader agents and an SDRAM controller model
module tb_sdram_port_arbiter;
  localparam int AW = 25, DW = 8, TMO = 255;
  logic clk = 1'b0, reset = 1'b1, dl_wr = 1'b0, rd_req = 1'b0, sd_ack = 1'b0;
  logic [AW-1:0] dl_addr = '0, rd_addr = '0;
  logic [DW-1:0] dl_data = '0, sd_dout = '0;
  logic dl_wait, rd_valid, sd_we, sd_rd, tmo_err;
  logic [DW-1:0] rd_data, sd_din;
  logic [AW-1:0] sd_addr;

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_wait(dl_wait), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_rd(sd_rd),
    .sd_dout(sd_dout), .sd_ack(sd_ack), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct {bit w; logic [AW-1:0] addr; logic [DW-1:0] data; int cyc;} cmd_t;
  typedef struct {logic [DW-1:0] data; int cyc;} rv_t;
  cmd_t cmd_q[$];
  cmd_t wr_exp[$];
  rv_t rv_q[$];
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] rd_exp[$];
  logic [AW+DW-1:0] dl_q[$];
  int rd_req_cyc[$];
  int ack_cyc[$];
  logic [DW-1:0] mem[int];
  bit wait_hist[int];
  int cyc = 0, vectors = 0, errors = 0;
  int ack_dly = 3, ack_at = -1, rv_total = 0, rd_seen = 0;
  bit rnd_dly = 0, dl_eager = 0, ack_w = 0;
  logic [AW-1:0] ack_addr = '0;
  logic [DW-1:0] ack_data = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SDRAM controller model: logs every command cycle and acks after a chosen delay
  initial begin
    cmd_t c;
    rv_t r;
    forever begin
      @(negedge clk);
      wait_hist[cyc] = dl_wait;
      if (rd_valid) begin
        r.data = rd_data;
        r.cyc = cyc;
        rv_q.push_back(r);
        rv_total++;
      end
      if (sd_we || sd_rd) begin
        c.w = sd_we;
        c.addr = sd_addr;
        c.data = sd_din;
        c.cyc = cyc;
        cmd_q.push_back(c);
        ack_w = sd_we;
        ack_addr = sd_addr;
        ack_data = sd_din;
        ack_at = ack_dly < 0 ? -1 : cyc + (rnd_dly ? int'($urandom_range(1, 5)) : ack_dly);
      end
      sd_ack = (cyc == ack_at);
      sd_dout = DW'($urandom);
      if (cyc == ack_at) begin
        ack_cyc.push_back(cyc);
        if (ack_w) mem[int'(ack_addr)] = ack_data;
        else sd_dout = mem.exists(int'(ack_addr)) ? mem[int'(ack_addr)] : 8'hEE;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    dl_wr = 1'b0;
    if (dl_q.size() > 0 && (!dl_wait || (dl_eager && ack_at == cyc && ack_w))) begin
      cmd_t c;
      {dl_addr, dl_data} = dl_q.pop_front();
      dl_wr = 1'b1;
      c.w = 1'b1;
      c.addr = dl_addr;
      c.data = dl_data;
      c.cyc = cyc;
      wr_exp.push_back(c);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rd_req && rv_total > rd_seen) rd_req = 1'b0;
    rd_seen = rv_total;
    if (!rd_req && rd_q.size() > 0) begin
      rd_addr = rd_q.pop_front();
      rd_req = 1'b1;
      rd_exp.push_back(rd_addr);
      rd_req_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic clear_logs;
    cmd_q.delete();
    wr_exp.delete();
    rv_q.delete();
    rd_exp.delete();
    rd_req_cyc.delete();
    ack_cyc.delete();
  endtask

  task automatic wait_for(input int ncmd, input int nrv, input int limit, output bit ok);
    int n = 0;
    while ((cmd_q.size() < ncmd || rv_q.size() < nrv) && n < limit) begin
      idle(1);
      n++;
    end
    ok = cmd_q.size() >= ncmd && rv_q.size() >= nrv;
  endtask

  function automatic logic [AW-1:0] rand_rd_addr;
    logic [AW-1:0] a = AW'(32'h100000 + $urandom_range(0, 4095));
    if (!mem.exists(int'(a))) mem[int'(a)] = DW'($urandom);
    return a;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    vectors++;
    if ({dl_wait, rd_valid, rd_data, sd_we, sd_rd, sd_addr, sd_din, tmo_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {dl_wait, rd_valid, rd_data, sd_we, sd_rd, sd_addr, sd_din, tmo_err});
    end
    reset = 1'b0;
    idle(3);
    vectors++;
    if ({dl_wait, rd_valid, sd_we, sd_rd, tmo_err} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle got %b want 00000", {dl_wait, rd_valid, sd_we, sd_rd, tmo_err});
    end
  endtask

  task automatic test_single_read;
    bit ok;
    clear_logs();
    ack_dly = 4;
    mem[32'h123] = 8'h5A;
    rd_q.push_back(AW'(32'h123));
    wait_for(1, 1, 60, ok);
    idle(5);
    vectors++;
    if (!ok || cmd_q.size() != 1 || rv_q.size() != 1) begin
      errors++;
      $display("FAIL t1_counts got cmds=%0d rv=%0d want 1/1", cmd_q.size(), rv_q.size());
    end else begin
      vectors++;
      if ({cmd_q[0].w, cmd_q[0].addr} !== {1'b0, AW'(32'h123)}) begin
        errors++;
        $display("FAIL t1_cmd got w=%0b addr=%h want read 123", cmd_q[0].w, cmd_q[0].addr);
      end
      vectors++;
      if (cmd_q[0].cyc !== rd_req_cyc[0] + 2) begin
        errors++;
        $display("FAIL t1_rd_latency got %0d want %0d", cmd_q[0].cyc, rd_req_cyc[0] + 2);
      end
      vectors++;
      if (rv_q[0].data !== 8'h5A || rv_q[0].cyc !== cmd_q[0].cyc + 5) begin
        errors++;
        $display("FAIL t1_rd_valid got %h@%0d want 5a@%0d", rv_q[0].data, rv_q[0].cyc, cmd_q[0].cyc + 5);
      end
    end
    vectors++;
    if (rd_data !== 8'h5A) begin
      errors++;
      $display("FAIL t1_rd_data_hold got %h want 5a", rd_data);
    end
  endtask

  task automatic test_burst;
    bit ok;
    clear_logs();
    ack_dly = 3;
    dl_q.push_back({AW'(0), 8'hA1});
    dl_q.push_back({AW'(1), 8'hB2});
    dl_q.push_back({AW'(2), 8'hC3});
    wait_for(3, 0, 100, ok);
    idle(6);
    vectors++;
    if (!ok || cmd_q.size() != 3 || wr_exp.size() != 3) begin
      errors++;
      $display("FAIL t2_counts got cmds=%0d sent=%0d want 3/3", cmd_q.size(), wr_exp.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if ({cmd_q[i].w, cmd_q[i].addr, cmd_q[i].data} !== {1'b1, wr_exp[i].addr, wr_exp[i].data}) begin
          errors++;
          $display("FAIL t2_write%0d got w=%0b %h/%h want write %h/%h", i, cmd_q[i].w, cmd_q[i].addr,
                   cmd_q[i].data, wr_exp[i].addr, wr_exp[i].data);
        end
      end
      vectors++;
      if (cmd_q[0].cyc !== wr_exp[0].cyc + 2) begin
        errors++;
        $display("FAIL t2_wr_latency got %0d want %0d", cmd_q[0].cyc, wr_exp[0].cyc + 2);
      end
    end
    vectors++;
    if ({dl_wait, sd_addr, sd_din} !== {1'b0, AW'(2), 8'hC3}) begin
      errors++;
      $display("FAIL t2_final got wait=%0b %h/%h want 0 2/c3", dl_wait, sd_addr, sd_din);
    end
  endtask

  task automatic test_alternate;
    bit ok;
    int wi = 0, ri = 0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    clear_logs();
    rnd_dly = 1;
    for (int i = 0; i < 6; i++) begin
      dl_q.push_back({AW'(32'h1000 + i), DW'($urandom)});
      rd_q.push_back(rand_rd_addr());
    end
    wait_for(12, 6, 600, ok);
    idle(8);
    rnd_dly = 0;
    vectors++;
    if (!ok || cmd_q.size() != 12 || rv_q.size() != 6 || wr_exp.size() != 6) begin
      errors++;
      $display("FAIL t3_counts got cmds=%0d rv=%0d want 12/6", cmd_q.size(), rv_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        vectors++;
        if (cmd_q[i].w !== (i % 2 == 0)) begin
          errors++;
          $display("FAIL t3_grant%0d got w=%0b want %0b", i, cmd_q[i].w, i % 2 == 0);
        end else if (cmd_q[i].w) begin
          vectors++;
          if ({cmd_q[i].addr, cmd_q[i].data} !== {wr_exp[wi].addr, wr_exp[wi].data}) begin
            errors++;
            $display("FAIL t3_write%0d got %h/%h want %h/%h", wi, cmd_q[i].addr, cmd_q[i].data,
                     wr_exp[wi].addr, wr_exp[wi].data);
          end
          wi++;
        end else begin
          vectors++;
          if (cmd_q[i].addr !== rd_exp[ri] || rv_q[ri].data !== mem[int'(rd_exp[ri])]) begin
            errors++;
            $display("FAIL t3_read%0d got %h->%h want %h->%h", ri, cmd_q[i].addr, rv_q[ri].data,
                     rd_exp[ri], mem[int'(rd_exp[ri])]);
          end
          ri++;
        end
      end
    end
  endtask

  task automatic test_refill;
    bit ok;
    clear_logs();
    ack_dly = 3;
    dl_eager = 1;
    for (int i = 0; i < 4; i++) dl_q.push_back({AW'(32'h2000 + i), DW'($urandom)});
    wait_for(4, 0, 100, ok);
    idle(6);
    dl_eager = 0;
    vectors++;
    if (!ok || cmd_q.size() != 4 || wr_exp.size() != 4 || ack_cyc.size() != 4) begin
      errors++;
      $display("FAIL t4_counts got cmds=%0d sent=%0d want 4/4", cmd_q.size(), wr_exp.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if ({cmd_q[i].addr, cmd_q[i].data} !== {wr_exp[i].addr, wr_exp[i].data}) begin
          errors++;
          $display("FAIL t4_write%0d got %h/%h want %h/%h", i, cmd_q[i].addr, cmd_q[i].data,
                   wr_exp[i].addr, wr_exp[i].data);
        end
        vectors++;
        if (wait_hist[ack_cyc[i] + 1] !== (i < 3)) begin
          errors++;
          $display("FAIL t4_wait_after_ack%0d got %0b want %0b", i, wait_hist[ack_cyc[i] + 1], i < 3);
        end
      end
      vectors++;
      if (wr_exp[1].cyc !== ack_cyc[0]) begin
        errors++;
        $display("FAIL t4_refill_cycle got %0d want %0d", wr_exp[1].cyc, ack_cyc[0]);
      end
    end
  endtask

  task automatic test_timeout;
    bit ok;
    logic [AW-1:0] a;
    for (int k = 0; k < 3; k++) begin
      clear_logs();
      ack_dly = k == 0 ? TMO - 1 : (k == 1 ? -1 : 2);
      a = rand_rd_addr();
      rd_q.push_back(a);
      wait_for(1, 1, 400, ok);
      idle(3);
      vectors++;
      if (!ok || cmd_q.size() != 1 || rv_q.size() != 1) begin
        errors++;
        $display("FAIL t5_counts%0d got cmds=%0d rv=%0d want 1/1", k, cmd_q.size(), rv_q.size());
      end else begin
        vectors++;
        if (rv_q[0].cyc !== cmd_q[0].cyc + (k == 2 ? 3 : TMO)) begin
          errors++;
          $display("FAIL t5_latency%0d got %0d want %0d", k, rv_q[0].cyc, cmd_q[0].cyc + (k == 2 ? 3 : TMO));
        end
        vectors++;
        if (rv_q[0].data !== (k == 1 ? 8'h00 : mem[int'(a)])) begin
          errors++;
          $display("FAIL t5_data%0d got %h want %h", k, rv_q[0].data, k == 1 ? 8'h00 : mem[int'(a)]);
        end
      end
      vectors++;
      if (tmo_err !== (k != 0)) begin
        errors++;
        $display("FAIL t5_tmo_err%0d got %0b want %0b", k, tmo_err, k != 0);
      end
    end
    clear_logs();
    ack_dly = -1;
    dl_q.push_back({AW'(32'h2800), 8'h77});
    wait_for(1, 0, 20, ok);
    idle(TMO + 4);
    vectors++;
    if (!ok || cmd_q.size() != 1) begin
      errors++;
      $display("FAIL t5_wr_counts got cmds=%0d want 1", cmd_q.size());
    end else begin
      vectors++;
      if ({wait_hist[cmd_q[0].cyc + TMO - 1], wait_hist[cmd_q[0].cyc + TMO], dl_wait} !== 3'b100) begin
        errors++;
        $display("FAIL t5_wr_free got %b want 100", {wait_hist[cmd_q[0].cyc + TMO - 1],
                 wait_hist[cmd_q[0].cyc + TMO], dl_wait});
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [AW-1:0] a;
    clear_logs();
    ack_dly = 8;
    dl_q.push_back({AW'(32'h3000), 8'h99});
    wait_for(1, 0, 20, ok);
    reset = 1'b1;
    idle(2);
    vectors++;
    if ({dl_wait, rd_valid, rd_data, sd_we, sd_rd, sd_addr, sd_din, tmo_err} !== '0) begin
      errors++;
      $display("FAIL t6_in_reset got %h want 0", {dl_wait, rd_valid, rd_data, sd_we, sd_rd, sd_addr, sd_din, tmo_err});
    end
    reset = 1'b0;
    idle(10);
    vectors++;
    if (!ok || cmd_q.size() != 1 || rv_q.size() != 0 || ack_cyc.size() != 1) begin
      errors++;
      $display("FAIL t6_stale_ack got cmds=%0d rv=%0d acks=%0d want 1/0/1", cmd_q.size(), rv_q.size(), ack_cyc.size());
    end
    vectors++;
    if ({dl_wait, rd_valid, rd_data, sd_we, sd_rd, sd_addr, sd_din, tmo_err} !== '0) begin
      errors++;
      $display("FAIL t6_after_stale got %h want 0", {dl_wait, rd_valid, rd_data, sd_we, sd_rd, sd_addr, sd_din, tmo_err});
    end
    clear_logs();
    ack_dly = 3;
    a = rand_rd_addr();
    rd_q.push_back(a);
    wait_for(1, 1, 40, ok);
    vectors++;
    if (!ok || cmd_q[0].cyc !== rd_req_cyc[0] + 2 || rv_q[0].data !== mem[int'(a)]) begin
      errors++;
      $display("FAIL t6_next_read got ok=%0b cmds=%0d rv=%0d want serviced read of %h", ok,
               cmd_q.size(), rv_q.size(), mem[int'(a)]);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst();
    test_alternate();
    test_refill();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
